// File: rtl/musa_if_pkg.sv
// musa_if_pkg: shared constants and state encoding for the MUSA fetch stage.
package musa_if_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int IMEM_DEPTH_DEFAULT = 32;
    typedef enum logic {IF_RUN, IF_FAULT} if_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and IF/ID bundle builder for a synchronous-read instruction memory.
module instruction_fetch
    import musa_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic        fetch_fault
);
    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight_valid;
    if_state_t   state;

    // Stalls and faults re-read the in-flight word so imem_data stays stable.
    always_comb begin
        imem_address = reset ? RESET_PC
                     : redirect ? redirect_pc
                     : (stall || state == IF_FAULT) ? inflight_pc
                     : fetch_pc;
    end

    always_comb begin
        if_id_valid   = inflight_valid && !redirect && state == IF_RUN;
        if_id_instr   = if_id_valid ? imem_data : NOP_INSTR;
        if_id_pc      = inflight_pc;
        if_id_pc_next = inflight_pc + 32'd1;
        fetch_fault   = state == IF_FAULT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight_valid <= 1'b0;
            state          <= IF_RUN;
        end else if (redirect) begin
            if (redirect_pc < DEPTH) begin
                inflight_pc    <= redirect_pc;
                inflight_valid <= 1'b1;
                fetch_pc       <= redirect_pc + 32'd1;
                state          <= IF_RUN;
            end else begin
                inflight_valid <= 1'b0;
                fetch_pc       <= redirect_pc;
                state          <= IF_FAULT;
            end
        end else if (!stall && state == IF_RUN) begin
            if (fetch_pc < DEPTH) begin
                inflight_pc    <= fetch_pc;
                inflight_valid <= 1'b1;
                fetch_pc       <= fetch_pc + 32'd1;
            end else begin
                inflight_valid <= 1'b0;
                state          <= IF_FAULT;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a per-cycle bundle model plus literal spot checks.
module tb_instruction_fetch;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_address;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic        if_id_valid;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32];

    instruction_fetch #(.RESET_PC(32'd0), .IMEM_DEPTH(32)) dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_address(imem_address), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next),
        .if_id_valid(if_id_valid), .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < 32; i++) mem[i] = 32'(i + 100);

    always @(posedge clock)
        imem_data <= (imem_address < 32) ? mem[imem_address[4:0]] : 32'hDEAD_BEEF;

    // Model: which word decode should be holding, whether it is real, and what comes next.
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_next = 32'd0;
    logic        m_ok = 1'b0;
    logic        m_halt = 1'b0;
    logic        armed = 1'b0;

    always @(posedge clock) begin
        armed <= 1'b1;
        if (reset) begin
            m_pc <= 32'd0; m_next <= 32'd0; m_ok <= 1'b0; m_halt <= 1'b0;
        end else if (redirect) begin
            if (redirect_pc < 32) begin
                m_pc <= redirect_pc; m_next <= redirect_pc + 1; m_ok <= 1'b1; m_halt <= 1'b0;
            end else begin
                m_next <= redirect_pc; m_ok <= 1'b0; m_halt <= 1'b1;
            end
        end else if (!m_halt && !stall) begin
            if (m_next < 32) begin
                m_pc <= m_next; m_next <= m_next + 1; m_ok <= 1'b1;
            end else begin
                m_ok <= 1'b0; m_halt <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) if (armed) begin
        logic        e_valid;
        logic [31:0] e_addr;
        e_valid = m_ok && !redirect && !m_halt;
        e_addr = reset ? 32'd0 : redirect ? redirect_pc : (stall || m_halt) ? m_pc : m_next;
        check("model_valid", 32'(if_id_valid), 32'(e_valid));
        check("model_instr", if_id_instr, e_valid ? m_pc + 100 : 32'd0);
        check("model_pc", if_id_pc, m_pc);
        check("model_pc_next", if_id_pc_next, m_pc + 1);
        check("model_fault", 32'(fetch_fault), 32'(m_halt));
        check("model_addr", imem_address, e_addr);
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic spot(input string name, input logic [31:0] instr, input logic [31:0] pc,
                        input logic valid, input logic fault);
        @(negedge clock);
        check({name, "_instr"}, if_id_instr, instr);
        check({name, "_pc"}, if_id_pc, pc);
        check({name, "_valid"}, 32'(if_id_valid), 32'(valid));
        check({name, "_fault"}, 32'(fetch_fault), 32'(fault));
    endtask

    initial begin
        cycle(2);
        reset = 1'b0;
        spot("reset", 32'd0, 32'd0, 1'b0, 1'b0);
        check("reset_pc_next", if_id_pc_next, 32'd1);
        check("reset_addr", imem_address, 32'd0);
        cycle(1);
        spot("first", 32'd100, 32'd0, 1'b1, 1'b0);
        cycle(1);
        spot("second", 32'd101, 32'd1, 1'b1, 1'b0);
        cycle(1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            spot("stall", 32'd102, 32'd2, 1'b1, 1'b0);
            check("stall_addr", imem_address, 32'd2);
            cycle(1);
        end
        stall = 1'b0;
        cycle(1);
        spot("resume", 32'd103, 32'd3, 1'b1, 1'b0);
        cycle(1);
        redirect = 1'b1; redirect_pc = 32'd10;
        spot("redir_cycle", 32'd0, 32'd4, 1'b0, 1'b0);
        check("redir_addr", imem_address, 32'd10);
        cycle(1);
        redirect = 1'b0;
        spot("redir_target", 32'd110, 32'd10, 1'b1, 1'b0);
        check("redir_pc_next", if_id_pc_next, 32'd11);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'd7;
        cycle(1);
        redirect = 1'b0;
        spot("redir_stall", 32'd107, 32'd7, 1'b1, 1'b0);
        cycle(2);
        spot("hold7", 32'd107, 32'd7, 1'b1, 1'b0);
        stall = 1'b0;
        cycle(24);
        spot("last", 32'd131, 32'd31, 1'b1, 1'b0);
        cycle(1);
        spot("fault", 32'd0, 32'd31, 1'b0, 1'b1);
        cycle(2);
        spot("fault_hold", 32'd0, 32'd31, 1'b0, 1'b1);
        check("fault_addr", imem_address, 32'd31);
        redirect = 1'b1; redirect_pc = 32'd0;
        cycle(1);
        redirect = 1'b0;
        spot("recover", 32'd100, 32'd0, 1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 32'd40;
        cycle(1);
        redirect = 1'b0;
        spot("bad_target", 32'd0, 32'd0, 1'b0, 1'b1);
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd5;
        @(negedge clock);
        check("reset_wins_addr", imem_address, 32'd0);
        cycle(1);
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        spot("reset_from_fault", 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(3);
        stall = 1'b1;
        cycle(2);
        spot("pre_reset_stall", 32'd102, 32'd2, 1'b1, 1'b0);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        stall = 1'b0;
        spot("reset_from_stall", 32'd0, 32'd0, 1'b0, 1'b0);
        check("reset_stall_addr", imem_address, 32'd0);
        cycle(1);
        spot("restart", 32'd100, 32'd0, 1'b1, 1'b0);
        cycle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage front end of the MUSA core. Owns the program counter and drives the word address of the synchronous-read instruction memory, whose registered output (valid one cycle after the address) appears on `imem_data`. It tracks which PC each returning word belongs to and presents an IF/ID bundle to decode. The bundle carries instruction, PC, PC+1 and valid. The block handles stall, branch/jump redirect and out-of-range fetch faults.

## Interface
- `RESET_PC`, 0: word address fetched first after reset.
- `IMEM_DEPTH`, 32: number of instruction words; valid addresses are 0..IMEM_DEPTH-1.
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: decode cannot accept; hold the bundle.
- `redirect`  in  1: taken branch/jump from a later stage.
- `redirect_pc`  in  32: word-address target, sampled when `redirect`=1.
- `imem_address`  out  32: word address to instruction memory (combinational mux).
- `imem_data`  in  32: memory read data for the address presented last cycle.
- `if_id_instr`  out  32: instruction; forced to NOP (32'h0) when `if_id_valid`=0.
- `if_id_pc`  out  32: word address of `if_id_instr`.
- `if_id_pc_next`  out  32: `if_id_pc`+1.
- `if_id_valid`  out  1: bundle holds a real instruction.
- `fetch_fault`  out  1: fetch halted on out-of-range PC.

## Operation
- Registers:
  - `fetch_pc`: next address to issue.
  - `inflight_pc`: address whose data is on `imem_data`.
  - `inflight_valid`.
  - `state` ∈ {RUN, FAULT}.
- Address mux, in priority order:
  1. `redirect`=1 → `redirect_pc`.
  2. `stall`=1 → `inflight_pc`. The memory re-reads the same word, so `imem_data` stays stable.
  3. Otherwise → `fetch_pc`.
- RUN, no stall, no redirect: issue `fetch_pc`. On the clock edge:
  - `inflight_pc`←`fetch_pc`, `inflight_valid`←1.
  - `fetch_pc`←`fetch_pc`+1 (32-bit wrap, modulo 2^32).
- Stall without redirect: `fetch_pc`, `inflight_pc` and `inflight_valid` hold, and outputs stay constant.
- Redirect, in any state and regardless of `stall`:
  - `if_id_valid` is forced to 0 combinationally in the same cycle, so decode latches a bubble rather than the wrong-path word.
  - On the edge: `inflight_pc`←`redirect_pc`, `inflight_valid`←1, `fetch_pc`←`redirect_pc`+1, state←RUN.
- Range check: any address about to be issued that is ≥ `IMEM_DEPTH` is not issued. This applies to `fetch_pc` and to `redirect_pc`. On that edge:
  - state←FAULT and `inflight_valid`←0.
  - `fetch_pc` holds the faulting address.
- FAULT:
  - `fetch_fault`=1, `if_id_valid`=0.
  - `imem_address`=`inflight_pc`, and no PC advance.
  - Exit only by reset, or by a redirect to an in-range target.
- Outputs:
  - `if_id_valid` = `inflight_valid` & ~`redirect` & (state==RUN).
  - `if_id_instr` = `if_id_valid` ? `imem_data` : 0.
  - `if_id_pc` = `inflight_pc`.
  - `fetch_fault` = (state==FAULT).

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC`, `inflight_pc`=`RESET_PC`, `inflight_valid`=0, state=RUN.
  - Hence `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=`RESET_PC`, `if_id_pc_next`=`RESET_PC`+1, `fetch_fault`=0.
- During reset `imem_address`=`RESET_PC`.
- Latency:
  - First edge after reset release: bundle = mem[`RESET_PC`], valid=1.
  - Steady state: one instruction per cycle.
- Redirect: zero-bubble refill. The edge after the redirect cycle presents mem[target] valid. The redirect cycle itself shows valid=0.
- Reset mid-stall or mid-fault: reset wins over `stall`/`redirect`; all state returns to reset values on that edge.
- Combinational paths: `stall`, `redirect`, `redirect_pc` → `imem_address`; `redirect` → `if_id_valid`.

## Structure
- Shared package `musa_if_pkg` holds:
  - `NOP_INSTR` (32'h0).
  - State encoding `IF_RUN`/`IF_FAULT`.
  - Default `IMEM_DEPTH`.
- Single module, no sub-modules. The next-PC mux, range comparator and two-state FSM sit inline.

## Test plan
- Reset, memory preloaded mem[i]=i+100 → first edge after release: instr=100, pc=0, valid=1; then 101, 102… each cycle.
- Stall held 3 cycles at pc=2 → `imem_address`=2 throughout, instr=102 stable, valid=1; resumes at pc=3 on release.
- Redirect to 10 while pc=4 in IF/ID → valid=0 that cycle; next edge instr=110, pc=10, pc_next=11.
- Redirect and stall asserted together, target 7 → redirect wins; next edge pc=7 valid=1, stall then holds pc=7.
- Sequential fetch reaches pc=31 then 32 (`IMEM_DEPTH`=32) → pc=31 delivered valid; next edge `fetch_fault`=1, valid=0. Redirect to 0 clears it, next edge instr=100.
- Reset asserted in FAULT and mid-stall → next edge all outputs at reset values, `imem_address`=`RESET_PC`.
